// File: rtl/reg_seq_pkg.sv
// Shared FunSel encodings, sequencer state type and command helpers for reg_cmd_sequencer.
package reg_seq_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  typedef enum logic [1:0] {INIT, IDLE, RUN, FIN} seq_state_e;

  // INC/DEC take a step count; LOAD/CLEAR are always a single strobe.
  function automatic logic op_is_step(input logic [1:0] op);
    return (op == FS_DEC) || (op == FS_INC);
  endfunction

endpackage

// File: rtl/reg_cmd_sequencer_if.sv
// Command and register-strobe bundle between control unit, sequencer and target register.
// Carries the mismatch flag only when SEQ_SHADOW_CHECK_EN is defined.
interface reg_cmd_sequencer_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] reg_q;
  logic             reg_e;
  logic [1:0]       reg_funsel;
  logic [WIDTH-1:0] reg_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shadow;
`ifdef SEQ_SHADOW_CHECK_EN
  logic             mismatch;
`endif

  modport master (
`ifdef SEQ_SHADOW_CHECK_EN
    input  mismatch,
`endif
    output cmd_valid, cmd_op, cmd_data, cmd_count, reg_q,
    input  cmd_ready, reg_e, reg_funsel, reg_i, busy, done, shadow
  );

  modport slave (
`ifdef SEQ_SHADOW_CHECK_EN
    output mismatch,
`endif
    input  cmd_valid, cmd_op, cmd_data, cmd_count, reg_q,
    output cmd_ready, reg_e, reg_funsel, reg_i, busy, done, shadow
  );

endinterface

// File: rtl/step_down_counter.sv
// Loadable down-counter holding the number of RUN cycles still to follow the current one.
module step_down_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Expands dec/inc/load/clear commands into per-cycle FunSel register strobes and keeps a shadow.
// Define SEQ_SHADOW_CHECK_EN to add the sticky Reg_Q-vs-shadow mismatch flag.
module reg_cmd_sequencer
  import reg_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic                 clock,
  input logic                 reset,
  reg_cmd_sequencer_if.slave  bus
);

  seq_state_e       state_q;
  logic             reg_e_q, busy_q, done_q, ready_q;
  logic [1:0]       funsel_q;
  logic [WIDTH-1:0] shadow_q, data_q, reg_i;
  logic             accept, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_value;

  function automatic logic [WIDTH-1:0] next_shadow(input logic [1:0]       fs,
                                                   input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] din);
    case (fs)
      FS_DEC:  return cur - WIDTH'(1);
      FS_INC:  return cur + WIDTH'(1);
      FS_LOAD: return din;
      default: return '0;
    endcase
  endfunction

  assign accept       = bus.cmd_valid && ready_q;
  // Counter holds RUN cycles remaining after the current one, so a single step loads zero.
  assign cnt_load_val = op_is_step(bus.cmd_op) ? bus.cmd_count - CNT_W'(1) : '0;
  assign cnt_dec      = (state_q == RUN) && !cnt_zero;
  assign reg_i        = (reg_e_q && funsel_q == FS_LOAD) ? data_q : shadow_q;

  step_down_counter #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (accept),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= INIT;
      reg_e_q  <= 1'b0;
      funsel_q <= FS_LOAD;
      shadow_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      if (reg_e_q) shadow_q <= next_shadow(funsel_q, shadow_q, reg_i);
      unique case (state_q)
        // Clear strobe issues while IDLE still has ready low, keeping Busy up for that cycle.
        INIT: begin
          state_q  <= IDLE;
          reg_e_q  <= 1'b1;
          funsel_q <= FS_CLR;
        end
        IDLE, FIN: begin
          state_q  <= IDLE;
          reg_e_q  <= 1'b0;
          funsel_q <= FS_LOAD;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          ready_q  <= 1'b1;
          if (accept) begin
            data_q <= bus.cmd_data;
            if (op_is_step(bus.cmd_op) && bus.cmd_count == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q  <= RUN;
              reg_e_q  <= 1'b1;
              funsel_q <= bus.cmd_op;
              busy_q   <= 1'b1;
              ready_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (cnt_zero) begin
            state_q  <= FIN;
            reg_e_q  <= 1'b0;
            funsel_q <= FS_LOAD;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

`ifdef SEQ_SHADOW_CHECK_EN
  logic chk_q, mismatch_q;

  // chk_q skips INIT and the clear-strobe cycle, when the target is not yet known to be zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      chk_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      chk_q <= (state_q != INIT);
      if (chk_q && (bus.reg_q != shadow_q)) mismatch_q <= 1'b1;
    end
  end

  assign bus.mismatch = mismatch_q;
`else
  logic unused_reg_q;
  assign unused_reg_q = ^bus.reg_q;
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt_value;

  assign bus.cmd_ready  = ready_q;
  assign bus.reg_e      = reg_e_q;
  assign bus.reg_funsel = funsel_q;
  assign bus.reg_i      = reg_i;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.shadow     = shadow_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed, table-driven bench for reg_cmd_sequencer with a behavioural target register.
module tb_reg_cmd_sequencer;
  import reg_seq_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_cmd_sequencer_if #(.WIDTH(16), .CNT_W(8)) bus ();

  reg_cmd_sequencer #(.WIDTH(16), .CNT_W(8)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Target register that obeys the strobes; force_zero corrupts its output for the check test.
  logic [15:0] tgt_q = 16'h0000;
  logic        force_zero = 1'b0;
  always @(posedge clk) begin
    if (bus.reg_e) begin
      case (bus.reg_funsel)
        FS_DEC:  tgt_q <= tgt_q - 16'd1;
        FS_INC:  tgt_q <= tgt_q + 16'd1;
        FS_LOAD: tgt_q <= bus.reg_i;
        default: tgt_q <= 16'h0000;
      endcase
    end
  end
  assign bus.reg_q = force_zero ? 16'h0000 : tgt_q;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] data;
    logic [7:0]  count;
    int          steps;
    logic [15:0] exp_shadow;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    chk({v.name, ".ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_data  = v.data;
    bus.cmd_count = v.count;
    @(negedge clk);
    // Scramble the inputs after accept: the sequencer must use its latched copy.
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = ~v.data;
    bus.cmd_count = 8'hFF;
    for (int i = 0; i < v.steps; i++) begin
      chk({v.name, ".step_e"}, 32'(bus.reg_e), 32'd1);
      chk({v.name, ".step_fs"}, 32'(bus.reg_funsel), 32'(v.op));
      chk({v.name, ".step_busy"}, 32'(bus.busy), 32'd1);
      chk({v.name, ".step_done"}, 32'(bus.done), 32'd0);
      if (v.op == FS_LOAD) chk({v.name, ".step_ri"}, 32'(bus.reg_i), 32'(v.data));
      @(negedge clk);
    end
    chk({v.name, ".done"}, 32'(bus.done), 32'd1);
    chk({v.name, ".fin_e"}, 32'(bus.reg_e), 32'd0);
    chk({v.name, ".fin_fs"}, 32'(bus.reg_funsel), 32'(FS_LOAD));
    chk({v.name, ".fin_busy"}, 32'(bus.busy), 32'd0);
    chk({v.name, ".shadow"}, 32'(bus.shadow), 32'(v.exp_shadow));
    chk({v.name, ".park_ri"}, 32'(bus.reg_i), 32'(v.exp_shadow));
    @(negedge clk);
    chk({v.name, ".done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic reset_and_init(input string tag);
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, ".rst_e"}, 32'(bus.reg_e), 32'd0);
    chk({tag, ".rst_fs"}, 32'(bus.reg_funsel), 32'(FS_LOAD));
    chk({tag, ".rst_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".rst_ready"}, 32'(bus.cmd_ready), 32'd0);
    chk({tag, ".rst_shadow"}, 32'(bus.shadow), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk({tag, ".init_e"}, 32'(bus.reg_e), 32'd1);
    chk({tag, ".init_fs"}, 32'(bus.reg_funsel), 32'(FS_CLR));
    chk({tag, ".init_ready"}, 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk({tag, ".idle_e"}, 32'(bus.reg_e), 32'd0);
    chk({tag, ".idle_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".idle_shadow"}, 32'(bus.shadow), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"load1234", FS_LOAD, 16'h1234, 8'd0, 1, 16'h1234};
    vecs[1] = '{"inc2",     FS_INC,  16'h0000, 8'd2, 2, 16'h1236};
    vecs[2] = '{"dec3",     FS_DEC,  16'h0000, 8'd3, 3, 16'h1233};
    vecs[3] = '{"loadfffe", FS_LOAD, 16'hFFFE, 8'd7, 1, 16'hFFFE};
    vecs[4] = '{"inc3wrap", FS_INC,  16'h0000, 8'd3, 3, 16'h0001};
    vecs[5] = '{"dec2wrap", FS_DEC,  16'h0000, 8'd2, 2, 16'hFFFF};
    vecs[6] = '{"clear",    FS_CLR,  16'h5555, 8'd9, 1, 16'h0000};
    vecs[7] = '{"dec1wrap", FS_DEC,  16'h0000, 8'd1, 1, 16'hFFFF};
    vecs[8] = '{"loada5a5", FS_LOAD, 16'hA5A5, 8'd0, 1, 16'hA5A5};
    vecs[9] = '{"dec0",     FS_DEC,  16'h0000, 8'd0, 0, 16'hA5A5};

    bus.cmd_valid = 1'b0;
    bus.cmd_op    = FS_DEC;
    bus.cmd_data  = 16'h0000;
    bus.cmd_count = 8'd0;
    @(negedge clk);
    reset_and_init("por");
`ifdef SEQ_SHADOW_CHECK_EN
    chk("por.mismatch", 32'(bus.mismatch), 32'd0);
`endif

    foreach (vecs[i]) run_cmd(vecs[i]);

    // DEC 0 then CLEAR accepted in its Done cycle.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = FS_DEC;
    bus.cmd_count = 8'd0;
    @(negedge clk);
    chk("b2b.done0", 32'(bus.done), 32'd1);
    chk("b2b.no_e", 32'(bus.reg_e), 32'd0);
    chk("b2b.shadow0", 32'(bus.shadow), 32'hA5A5);
    chk("b2b.ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op = FS_CLR;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("b2b.clr_e", 32'(bus.reg_e), 32'd1);
    chk("b2b.clr_fs", 32'(bus.reg_funsel), 32'(FS_CLR));
    chk("b2b.clr_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("b2b.done1", 32'(bus.done), 32'd1);
    chk("b2b.shadow1", 32'(bus.shadow), 32'd0);
    @(negedge clk);

    // INC 10 interrupted by reset after four completed steps.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = FS_INC;
    bus.cmd_count = 8'd10;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort.step_e", 32'(bus.reg_e), 32'd1);
      @(negedge clk);
    end
    chk("abort.shadow4", 32'(bus.shadow), 32'd4);
    chk("abort.busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort.rst_e", 32'(bus.reg_e), 32'd0);
    chk("abort.rst_shadow", 32'(bus.shadow), 32'd0);
    chk("abort.rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.init_e", 32'(bus.reg_e), 32'd1);
    chk("abort.init_fs", 32'(bus.reg_funsel), 32'(FS_CLR));
    @(negedge clk);
    chk("abort.idle_e", 32'(bus.reg_e), 32'd0);
    chk("abort.idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort.idle_busy", 32'(bus.busy), 32'd0);

`ifdef SEQ_SHADOW_CHECK_EN
    run_cmd(vecs[0]);
    chk("mm.clean", 32'(bus.mismatch), 32'd0);
    force_zero = 1'b1;
    @(negedge clk);
    force_zero = 1'b0;
    @(negedge clk);
    chk("mm.set", 32'(bus.mismatch), 32'd1);
    repeat (3) @(negedge clk);
    chk("mm.sticky", 32'(bus.mismatch), 32'd1);
    reset_and_init("mmrst");
    chk("mm.cleared", 32'(bus.mismatch), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_cmd_sequencer.md
Name: reg_cmd_sequencer

Overview:
Command-side driver for a 16-bit FunSel-controlled register (dec/inc/load/clear). It accepts high-level commands over a valid/ready handshake and expands them into per-cycle Reg_E/Reg_FunSel/Reg_I strobes. It also keeps a shadow copy of the register contents. It sits between the control unit and one datapath register.

Parameters:
WIDTH, 16, data width of target register and shadow
CNT_W, 8, width of step-count field for INC/DEC commands

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  synchronous, active-low reset
Cmd_Valid  input  1  command request
Cmd_Ready  output  1  sequencer can accept a command this cycle
Cmd_Op  input  2  00 DEC, 01 INC, 10 LOAD, 11 CLEAR (same encoding as FunSel)
Cmd_Data  input  WIDTH  load value (LOAD only)
Cmd_Count  input  CNT_W  number of steps (INC/DEC only)
Reg_Q  input  WIDTH  current target register output
Reg_E  output  1  register operation strobe
Reg_FunSel  output  2  register function select
Reg_I  output  WIDTH  register load data
Busy  output  1  high from command accept until Done
Done  output  1  one-cycle pulse when a command completes
Shadow  output  WIDTH  expected register contents
Mismatch  output  1  sticky check flag (only with SEQ_SHADOW_CHECK_EN)

Behaviour:
- States: INIT, IDLE, RUN, FIN. All outputs except Reg_I are registered.
- Reset low at any edge, including mid-command: state=INIT, Reg_E=0, Reg_FunSel=2'b10, Shadow=0, Busy=1, Done=0, Cmd_Ready=0, step counter=0. Any command in progress is aborted.
- INIT: the first cycle after Reset rises drives Reg_E=1 and Reg_FunSel=2'b11 for exactly one cycle. This clears the target register to match Shadow=0. The sequencer then enters IDLE.
- IDLE: Cmd_Ready=1 and Busy=0. A command is accepted on Cmd_Valid&&Cmd_Ready. Cmd_Op, Cmd_Data and Cmd_Count are latched at accept.
- LOAD or CLEAR: one RUN cycle with Reg_E=1 and Reg_FunSel=Cmd_Op.
- INC or DEC with N=Cmd_Count>0: N consecutive RUN cycles with Reg_E=1 and Reg_FunSel=Cmd_Op. The step counter decrements once per cycle.
- INC or DEC with N=0: no Reg_E cycle; the sequencer goes straight to FIN.
- FIN: Done=1 for one cycle, Busy=0, Cmd_Ready=1. A new command may be accepted in the FIN cycle.
- Latency: accept at cycle t, register ops occur in t+1..t+N (N=1 for LOAD/CLEAR), Done at t+N+1.
- Idle parking: whenever Reg_E=0, Reg_FunSel=2'b10 and Reg_I=Shadow. A target that ignores E therefore reloads its own value.
- Reg_I source: during a LOAD RUN cycle, Reg_I=latched Cmd_Data. Reg_I is combinationally muxed from Shadow otherwise.
- Shadow update: on every edge where Reg_E=1, Shadow takes f(Reg_FunSel, Shadow, Reg_I): dec, inc, load or clear.
- Shadow arithmetic is modulo 2^WIDTH. 0xFFFF+1 wraps to 0x0000 and 0x0000-1 wraps to 0xFFFF, with no flag.
- Cmd_Valid while not ready is ignored. Command inputs need not be held stable after accept.

Optional Feature:
SEQ_SHADOW_CHECK_EN
- Defined: in IDLE, RUN and FIN (not INIT, and not the first cycle after INIT), Reg_Q is compared with Shadow every cycle.
- On any difference Mismatch is set. It is sticky until Reset and has reset value 0.
- Undefined: the Mismatch port and the compare logic are absent. Reg_Q remains an unused input.

Decomposition:
- Package reg_seq_pkg:
  - FunSel constants FS_DEC=2'b00, FS_INC=2'b01, FS_LOAD=2'b10, FS_CLR=2'b11.
  - State typedef {INIT, IDLE, RUN, FIN}.
- One sub-module, step_down_counter (CNT_W): load, decrement, zero flag. It tracks the remaining RUN cycles.

Test Plan:
- Reset low 3 cycles then high -> exactly one cycle of Reg_E=1 with FunSel=11; next cycle Cmd_Ready=1, Shadow=0x0000, Busy=0.
- LOAD Cmd_Data=0x1234 accepted at t -> t+1: Reg_E=1, FunSel=10, Reg_I=0x1234; t+2: Done=1, Shadow=0x1234, Reg_I=0x1234, Reg_E=0.
- Shadow=0xFFFE, INC Count=3 at t -> Reg_E=1 with FunSel=01 in t+1..t+3; Done at t+4; Shadow=0x0001 (wrap).
- DEC Count=0 at t -> no Reg_E pulse; Done at t+1; Shadow unchanged. Back-to-back CLEAR accepted in the Done cycle -> Reg_E with FunSel=11 at t+2.
- INC Count=10, Reset driven low after 4 steps -> next edge: Reg_E=0, Shadow=0, Busy=1; after release, one CLEAR cycle, then IDLE.
- SEQ_SHADOW_CHECK_EN: after LOAD 0x1234, bench forces Reg_Q=0x0000 for one cycle -> Mismatch=1 and stays 1 until Reset.
